// File: rtl/lut_cfg_pkg.sv
// Shared types and helpers for the LUT configuration loader.
package lut_cfg_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StShift,
    StCommit
  } state_e;

  // Number of host bytes needed to fill a chain of the given length.
  function automatic int unsigned bytes_for(int unsigned chain_bits);
    return (chain_bits + BYTE_W - 1) / BYTE_W;
  endfunction

endpackage

// File: rtl/cfg_byte_serializer.sv
// Holds one configuration byte and emits it LSB-first, one bit per shift.
module cfg_byte_serializer
  import lut_cfg_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [BYTE_W-1:0] data,
  input  logic              shift,
  input  logic              stop,
  output logic              data_bit,
  output logic              last_bit
);

  localparam int unsigned IdxW = $clog2(BYTE_W);

  logic [BYTE_W-1:0] sreg_q;
  logic [IdxW-1:0]   idx_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sreg_q <= '0;
      idx_q  <= '0;
    end else if (load) begin
      sreg_q <= data;
      idx_q  <= '0;
    end else if (shift) begin
      sreg_q <= sreg_q >> 1;
      idx_q  <= idx_q + IdxW'(1);
    end
  end

  assign data_bit = sreg_q[0];
  // stop truncates a partial final byte; remaining upper bits are dropped.
  assign last_bit = (idx_q == IdxW'(BYTE_W - 1)) || stop;

endmodule

// File: rtl/lut_config_loader.sv
// Accepts config bytes from a host and shifts them LSB-first into the LUT chain,
// then issues a single commit strobe.
module lut_config_loader
  import lut_cfg_pkg::*;
#(
  parameter int unsigned CHAIN_BITS = 16,
  parameter int unsigned CNT_W      = $clog2(CHAIN_BITS + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              cfg_bit,
  output logic              cfg_shift,
  output logic              cfg_commit,
  output logic              busy,
  output logic              done
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(CHAIN_BITS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             load;
  logic             stop;
  logic             ser_bit;
  logic             last_bit;

  // The bit being shifted this cycle is the final bit of the chain.
  assign stop = (cnt_q == LastCnt);

  cfg_byte_serializer u_ser (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .data     (in_data),
    .shift    (cfg_shift),
    .stop     (stop),
    .data_bit (ser_bit),
    .last_bit (last_bit)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFetch;
          cnt_d   = '0;
          done_d  = 1'b0;
        end
      end
      StFetch: begin
        if (in_valid) begin
          load    = 1'b1;
          state_d = StShift;
        end
      end
      StShift: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (last_bit) begin
          state_d = stop ? StCommit : StFetch;
        end
      end
      StCommit: begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  assign in_ready   = (state_q == StFetch);
  assign cfg_shift  = (state_q == StShift);
  assign cfg_bit    = cfg_shift & ser_bit;
  assign cfg_commit = (state_q == StCommit);
  assign busy       = (state_q != StIdle);
  assign done       = done_q;

endmodule
